// File: rtl/change_dispenser_if.sv
// Coin-return handshake bundle between the VM purchase FSM, the dispenser and the ejectors.
// The slave modport is the dispenser view; master is the VM/ejector-side view.
interface change_dispenser_if #(
  parameter int BAL_W = 8
);
  logic             start;
  logic [BAL_W-1:0] amount;
  logic             coin_ack;
  logic             ten_empty;
  logic             one_empty;
  logic             eject_ten;
  logic             eject_one;
  logic             busy;
  logic             done;
  logic             fault;
  logic [BAL_W-1:0] remaining;
  logic [2:0]       status;

  modport slave (
    input  start, amount, coin_ack, ten_empty, one_empty,
    output eject_ten, eject_one, busy, done, fault, remaining, status
  );

  modport master (
    output start, amount, coin_ack, ten_empty, one_empty,
    input  eject_ten, eject_one, busy, done, fault, remaining, status
  );
endinterface

// File: rtl/change_dispenser.sv
// Pays change as ten-yuan coins then one-yuan coins; each coin is an eject pulse plus ack.
// Per coin: 1 SEL + PULSE_CYC + ack wait; empty hoppers or ack timeout end in a sticky fault.
module change_dispenser #(
  parameter int BAL_W     = 8,
  parameter int PULSE_CYC = 4,
  parameter int TIMEOUT   = 255
) (
  input logic               clk,
  input logic               rst,
  change_dispenser_if.slave bus
);
  localparam int PC_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEL      = 3'd1,
    PULSE    = 3'd2,
    WAIT_ACK = 3'd3,
    DONE     = 3'd4,
    FAULT    = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [BAL_W-1:0] rem_q, rem_d;
  logic [PC_W-1:0]  pcnt_q, pcnt_d;
  logic [TO_W-1:0]  tcnt_q, tcnt_d;
  logic             ten_q, ten_d;
  logic             ack_seen_q, ack_seen_d;
  logic             fault_q, fault_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ej_ten_q, ej_ten_d;
  logic             ej_one_q, ej_one_d;
  logic [BAL_W-1:0] rem_dec;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    pcnt_d     = pcnt_q;
    tcnt_d     = tcnt_q;
    ten_d      = ten_q;
    ack_seen_d = ack_seen_q;
    fault_d    = fault_q;
    rem_dec    = rem_q - (ten_q ? BAL_W'(10) : BAL_W'(1));

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          fault_d = 1'b0;
          if (bus.amount != '0) begin
            rem_d   = bus.amount;
            state_d = SEL;
          end else begin
            state_d = DONE;
          end
        end
      end
      SEL: begin
        pcnt_d     = '0;
        ack_seen_d = 1'b0;
        if (rem_q == '0) begin
          state_d = DONE;
        end else if (rem_q >= BAL_W'(10) && !bus.ten_empty) begin
          ten_d   = 1'b1;
          state_d = PULSE;
        end else if (!bus.one_empty) begin
          ten_d   = 1'b0;
          state_d = PULSE;
        end else begin
          state_d = FAULT;
        end
      end
      PULSE: begin
        ack_seen_d = ack_seen_q | bus.coin_ack;
        if (pcnt_q == PC_W'(PULSE_CYC - 1)) begin
          // An ack already seen during the pulse completes the coin without WAIT_ACK.
          if (ack_seen_q || bus.coin_ack) begin
            rem_d      = rem_dec;
            ack_seen_d = 1'b0;
            state_d    = SEL;
          end else begin
            tcnt_d  = TO_W'(1);
            state_d = WAIT_ACK;
          end
        end else begin
          pcnt_d = pcnt_q + PC_W'(1);
        end
      end
      WAIT_ACK: begin
        if (bus.coin_ack) begin
          rem_d      = rem_dec;
          ack_seen_d = 1'b0;
          state_d    = SEL;
        end else if (tcnt_q == TO_W'(TIMEOUT)) begin
          state_d = FAULT;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == FAULT) fault_d = 1'b1;
    if (state_d == DONE)  rem_d   = '0;

    ej_ten_d = (state_d == PULSE) && ten_d;
    ej_one_d = (state_d == PULSE) && !ten_d;
    done_d   = (state_d == DONE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      pcnt_q     <= '0;
      tcnt_q     <= '0;
      ten_q      <= 1'b0;
      ack_seen_q <= 1'b0;
      fault_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ej_ten_q   <= 1'b0;
      ej_one_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      pcnt_q     <= pcnt_d;
      tcnt_q     <= tcnt_d;
      ten_q      <= ten_d;
      ack_seen_q <= ack_seen_d;
      fault_q    <= fault_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ej_ten_q   <= ej_ten_d;
      ej_one_q   <= ej_one_d;
    end
  end

  assign bus.eject_ten = ej_ten_q;
  assign bus.eject_one = ej_one_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;
  assign bus.remaining = rem_q;
  assign bus.status    = state_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench: stimulus queues expected coin/done/fault events, a negedge monitor pops and compares.
module tb_change_dispenser;
  localparam int K_TEN = 0, K_ONE = 1, K_DONE = 2, K_FAULT = 3;

  typedef struct {
    int kind;
    int width;
    int val;
  } ev_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;
  int   ack_mode;
  ev_t  exp_q[$];

  change_dispenser_if #(.BAL_W(8)) bus ();

  change_dispenser #(.BAL_W(8), .PULSE_CYC(4), .TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int k, input int w, input int v);
    ev_t e;
    e.kind  = k;
    e.width = w;
    e.val   = v;
    exp_q.push_back(e);
  endtask

  task automatic got(input int k, input int w, input int v);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL event: got kind=%0d width=%0d rem=%0d, required no event", k, w, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.width != w || e.val != v) begin
        n_err++;
        $display("FAIL event: got kind=%0d width=%0d rem=%0d, required kind=%0d width=%0d rem=%0d",
                 k, w, v, e.kind, e.width, e.val);
      end
    end
  endtask

  // Monitor: turns output activity into events (pulse end with width and remaining at pulse start).
  initial begin : monitor
    int   wt, wo, rt, ro;
    logic pt, po, pf;
    wt = 0; wo = 0; rt = 0; ro = 0;
    pt = 1'b0; po = 1'b0; pf = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.eject_ten === 1'b1) begin
        if (!pt) begin
          wt = 0;
          rt = int'(bus.remaining);
        end
        wt++;
      end else if (pt) begin
        got(K_TEN, wt, rt);
      end
      if (bus.eject_one === 1'b1) begin
        if (!po) begin
          wo = 0;
          ro = int'(bus.remaining);
        end
        wo++;
      end else if (po) begin
        got(K_ONE, wo, ro);
      end
      if (bus.done === 1'b1) got(K_DONE, 0, int'(bus.remaining));
      if (bus.fault === 1'b1 && !pf) got(K_FAULT, 0, int'(bus.remaining));
      pt = (bus.eject_ten === 1'b1);
      po = (bus.eject_one === 1'b1);
      pf = (bus.fault === 1'b1);
    end
  end

  // Ejector model: mode 1 acks in the first WAIT_ACK cycle, mode 2 acks in pulse cycle 2.
  initial begin : responder
    int pc;
    pc = 0;
    bus.coin_ack = 1'b0;
    forever begin
      @(negedge clk);
      pc = (bus.eject_ten === 1'b1 || bus.eject_one === 1'b1) ? pc + 1 : 0;
      case (ack_mode)
        1:       bus.coin_ack = (bus.status == 3'd3);
        2:       bus.coin_ack = (pc == 2);
        default: bus.coin_ack = 1'b0;
      endcase
    end
  end

  task automatic do_start(input int amt);
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.amount = 8'(amt);
    @(posedge clk); #1;
    bus.start  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int req_cyc, input int budget);
    int n;
    n = 0;
    while (bus.status != 3'd0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, n, req_cyc);
  endtask

  initial begin : stim
    n_checks      = 0;
    n_err         = 0;
    ack_mode      = 1;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.amount    = '0;
    bus.ten_empty = 1'b0;
    bus.one_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset status", int'(bus.status), 0);
    chk("reset remaining", int'(bus.remaining), 0);
    chk("reset outputs", int'({bus.eject_ten, bus.eject_one, bus.busy, bus.done, bus.fault}), 0);
    rst = 1'b0;

    // 23 yuan: two tens, three ones
    push(K_TEN, 4, 23); push(K_TEN, 4, 13);
    push(K_ONE, 4, 3);  push(K_ONE, 4, 2); push(K_ONE, 4, 1);
    push(K_DONE, 0, 0);
    do_start(23);
    chk("t1 busy after start", int'(bus.busy), 1);
    chk("t1 status SEL", int'(bus.status), 1);
    wait_idle("t1 cycles", 32, 200);
    chk("t1 remaining end", int'(bus.remaining), 0);

    // 12 yuan with ten hopper empty: twelve ones
    bus.ten_empty = 1'b1;
    for (int i = 12; i >= 1; i--) push(K_ONE, 4, i);
    push(K_DONE, 0, 0);
    do_start(12);
    wait_idle("t2 cycles", 74, 300);
    chk("t2 fault", int'(bus.fault), 0);
    bus.ten_empty = 1'b0;

    // 5 yuan with one hopper empty: fault straight out of SEL
    bus.one_empty = 1'b1;
    push(K_FAULT, 0, 5);
    do_start(5);
    @(posedge clk); #1;
    chk("t3 status FAULT", int'(bus.status), 5);
    wait_idle("t3 cycles", 1, 20);
    repeat (3) @(posedge clk);
    #1;
    chk("t3 fault sticky", int'(bus.fault), 1);
    chk("t3 remaining", int'(bus.remaining), 5);
    bus.one_empty = 1'b0;
    push(K_ONE, 4, 1); push(K_DONE, 0, 0);
    do_start(1);
    chk("t3 fault cleared", int'(bus.fault), 0);
    wait_idle("t3b cycles", 8, 50);

    // 1 yuan, no ack: timeout fault
    ack_mode = 0;
    push(K_ONE, 4, 1); push(K_FAULT, 0, 1);
    do_start(1);
    wait_idle("t4 cycles", 261, 400);
    chk("t4 fault", int'(bus.fault), 1);
    chk("t4 remaining", int'(bus.remaining), 1);

    // 10 yuan, ack during pulse: WAIT_ACK skipped
    ack_mode = 2;
    push(K_TEN, 4, 10); push(K_DONE, 0, 0);
    do_start(10);
    chk("t5 fault cleared", int'(bus.fault), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t5 status SEL after pulse", int'(bus.status), 1);
    chk("t5 remaining after pulse", int'(bus.remaining), 0);
    wait_idle("t5 cycles", 2, 20);

    // 30 yuan: start while busy ignored, then reset during second ten pulse
    ack_mode = 1;
    push(K_TEN, 4, 30); push(K_TEN, 2, 20);
    do_start(30);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.amount = 8'd7;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    chk("t6 remaining ignores start", int'(bus.remaining), 30);
    chk("t6 status PULSE", int'(bus.status), 2);
    repeat (5) @(posedge clk);
    #1;
    chk("t6 eject_ten before rst", int'(bus.eject_ten), 1);
    #5;
    rst = 1'b1;
    #1;
    chk("t6 eject_ten in rst", int'(bus.eject_ten), 0);
    chk("t6 outputs in rst", int'({bus.eject_one, bus.busy, bus.done, bus.fault}), 0);
    chk("t6 remaining in rst", int'(bus.remaining), 0);
    chk("t6 status in rst", int'(bus.status), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("t6 status held in rst", int'(bus.status), 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6 idle after rst", int'(bus.status), 0);
    chk("events outstanding", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Sequences the coin-return actuator of the vending machine.
- Given a change amount in yuan, it pays ten-yuan coins first, then one-yuan coins, one coin at a time.
- Each coin uses an eject pulse followed by an acknowledge handshake. Hopper-empty conditions and acknowledge timeouts are handled.
- Sits between the VM balance/purchase FSM, which issues start and amount, and the physical coin ejectors.

Parameters:
BAL_W, 8, width of amount/remaining in yuan
PULSE_CYC, 4, eject pulse length in clock cycles (>=1)
TIMEOUT, 255, max cycles spent in WAIT_ACK before fault (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request to dispense; honoured only in IDLE
amount  input  BAL_W  change to pay, sampled when start is accepted
coin_ack  input  1  ejector confirms one coin dropped
ten_empty  input  1  ten-yuan hopper empty
one_empty  input  1  one-yuan hopper empty
eject_ten  output  1  drive ten-yuan ejector
eject_one  output  1  drive one-yuan ejector
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the full amount has been paid
fault  output  1  sticky error flag
remaining  output  BAL_W  amount still unpaid
status  output  3  state code

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0, including remaining. Pulse and timeout counters cleared. Reset mid-dispense aborts immediately; the ejector is released the same instant.
- State codes: IDLE=0, SEL=1, PULSE=2, WAIT_ACK=3, DONE=4, FAULT=5. All outputs are registered.
- IDLE:
  - start=1 and amount!=0: remaining<=amount, fault<=0, go to SEL.
  - start=1 and amount==0: fault<=0, go to DONE.
  - All other inputs ignored.
- SEL (1 cycle), evaluated in priority order:
  - remaining==0: go to DONE.
  - remaining>=10 and !ten_empty: coin=TEN, go to PULSE.
  - !one_empty: coin=ONE, go to PULSE. This includes remaining>=10 with ten_empty=1 (fallback to ones).
  - Otherwise: go to FAULT.
- PULSE:
  - eject_ten or eject_one (per coin) is high for exactly PULSE_CYC cycles, then WAIT_ACK.
  - coin_ack seen at any clock edge in PULSE is latched (ack_seen).
  - If ack_seen at pulse end: skip WAIT_ACK, do the decrement, go to SEL.
- WAIT_ACK:
  - Ejectors low.
  - coin_ack=1: decrement, go to SEL.
  - Cycle counter starts at 1 on entry. Reaching TIMEOUT cycles with no ack goes to FAULT; remaining is not decremented.
- Decrement: remaining<=remaining-10 for TEN, -1 for ONE. Underflow is impossible by construction. ack_seen is cleared.
- DONE: done=1 for one cycle, remaining=0, then IDLE.
- FAULT: fault<=1 for one cycle, then IDLE. fault stays high until the next accepted start. remaining holds the unpaid amount for the VM to display. done is not asserted.
- Edge cases:
  - start while busy is ignored.
  - coin_ack in IDLE, SEL or DONE is ignored.
  - Multiple acks during one PULSE count as one coin.
  - Hopper-empty inputs are sampled only in SEL; a hopper emptying mid-pulse does not affect the current coin.
- Per-coin latency with ack in the first WAIT_ACK cycle: 1 (SEL) + PULSE_CYC + 1 = 6 cycles at defaults.

Test Plan:
- Reset, then start with amount=23; ack on the first WAIT_ACK cycle of each coin -> two eject_ten pulses, then three eject_one pulses, each 4 cycles wide. remaining steps 23,13,3,2,1,0. A single done pulse follows; busy is high from the cycle after start through DONE. status returns to 0.
- amount=12, ten_empty=1 -> twelve eject_one pulses, no eject_ten, done=1, fault=0.
- amount=5, one_empty=1 -> no eject pulses. FAULT is reached 2 cycles after start; fault=1 sticky; remaining=5. A subsequent start with amount=1 and one_empty=0 clears fault and completes.
- amount=1, coin_ack never asserted -> one eject_one pulse, then fault=1 after 255 WAIT_ACK cycles. remaining=1, done never pulses.
- amount=10, coin_ack asserted during PULSE cycle 2 -> WAIT_ACK is skipped. remaining=0 at pulse end; done follows SEL and DONE.
- Mid-dispense: amount=30, assert rst during the second eject_ten pulse -> eject_ten drops immediately. All outputs are 0 and status=0 while rst is high. start is ignored while busy, checked by asserting start with amount=7 mid-sequence with no change in remaining.
